regfile_write_scheduler: RTL and testbench

REGFILE_WRITE_SCHEDULER -- requirements
Module: regfile_write_scheduler

---
 rtl/regfile_write_scheduler_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/regfile_write_scheduler.sv | 100 ++++++++++
 tb/tb_regfile_write_scheduler.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_scheduler_pkg.sv
// Shared definitions for the register-file write scheduler: default sizes
// and the scheduler FSM encoding.
package regfile_write_scheduler_pkg;

  localparam int DEFAULT_N    = 32;
  localparam int DEFAULT_REGS = 32;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. On a tie it grants the requester that was not
// granted last; the pointer only moves when the caller reports an acceptance.
module rr_arbiter2 (
  input  logic clk,
  input  logic reset,
  input  logic valid0,
  input  logic valid1,
  input  logic advance,
  output logic grant
);

  logic last;

  always_comb begin
    grant = 1'b0;
    if (valid0 && valid1) grant = ~last;
    else if (valid1)      grant = 1'b1;
  end

  // Reset to "req1 was last" so req0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset)       last <= 1'b1;
    else if (advance) last <= grant;
  end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Schedules two write requesters and a bulk clear (x1..xREGS-1) onto the
// single register-file write port; all write-port outputs are registered.
module regfile_write_scheduler
  import regfile_write_scheduler_pkg::*;
#(
  parameter int N    = DEFAULT_N,
  parameter int REGS = DEFAULT_REGS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req0_valid,
  input  logic [$clog2(REGS)-1:0] req0_addr,
  input  logic [N-1:0]            req0_data,
  output logic                    req0_ready,
  input  logic                    req1_valid,
  input  logic [$clog2(REGS)-1:0] req1_addr,
  input  logic [N-1:0]            req1_data,
  output logic                    req1_ready,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic [REGS-1:0]         wr_enable,
  output logic [N-1:0]            wr_data,
  output logic                    grant_id,
  output state_t                  fsm_state
);

  localparam int AW = $clog2(REGS);
  localparam logic [REGS-1:0] ONE = REGS'(1);
  localparam logic [AW-1:0]   LAST_REG = AW'(REGS - 1);

  state_t        state;
  logic [AW-1:0] counter;
  logic          grant;
  logic          accept;
  logic          open;
  logic [AW-1:0] sel_addr;
  logic [N-1:0]  sel_data;

  // Handshake: a request transfers on a rising edge where valid and ready are
  // both high; a requester holds addr/data stable until it sees ready.
  assign open       = reset && (state == ARB) && !clr_start;
  assign req0_ready = open && req0_valid && (grant == 1'b0);
  assign req1_ready = open && req1_valid && (grant == 1'b1);
  assign accept     = req0_ready || req1_ready;
  assign sel_addr   = grant ? req1_addr : req0_addr;
  assign sel_data   = grant ? req1_data : req0_data;
  assign fsm_state  = state;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .valid0  (req0_valid),
    .valid1  (req1_valid),
    .advance (accept),
    .grant   (grant)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ARB;
      wr_enable <= '0;
      wr_data   <= '0;
      grant_id  <= 1'b0;
      clr_busy  <= 1'b0;
      counter   <= AW'(1);
    end else begin
      case (state)
        ARB: begin
          if (clr_start) begin
            // x1 goes out immediately; with only two registers the clear ends here.
            state     <= (REGS > 2) ? CLEAR : ARB;
            wr_enable <= ONE << 1;
            wr_data   <= '0;
            grant_id  <= 1'b0;
            clr_busy  <= 1'b1;
            counter   <= AW'(2);
          end else if (accept) begin
            wr_enable <= (sel_addr == '0) ? '0 : (ONE << sel_addr);
            wr_data   <= sel_data;
            grant_id  <= grant;
            clr_busy  <= 1'b0;
          end else begin
            wr_enable <= '0;
            clr_busy  <= 1'b0;
          end
        end
        CLEAR: begin
          wr_enable <= ONE << counter;
          wr_data   <= '0;
          grant_id  <= 1'b0;
          clr_busy  <= 1'b1;
          counter   <= counter + AW'(1);
          if (counter == LAST_REG) state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Bench for regfile_write_scheduler: directed scenarios followed by random
// traffic, all scored against a queue-based reference model.
module tb_regfile_write_scheduler;
  import regfile_write_scheduler_pkg::*;

  localparam int N    = 32;
  localparam int REGS = 32;
  localparam int AW   = 5;
  localparam int W    = 67;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [N-1:0]  req0_data = '0, req1_data = '0;
  logic          req0_ready, req1_ready;
  logic          clr_start = 1'b0;
  logic          clr_busy;
  logic [REGS-1:0] wr_enable;
  logic [N-1:0]  wr_data;
  logic          grant_id;
  state_t        fsm_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  regfile_write_scheduler #(.N(N), .REGS(REGS)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .clr_start  (clr_start),
    .clr_busy   (clr_busy),
    .wr_enable  (wr_enable),
    .wr_data    (wr_data),
    .grant_id   (grant_id),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pending clear addresses are a queue; a non-empty queue means clearing.
  int          last_g = 1;
  int          clr_q[$];
  logic [31:0] m_en = '0, m_data = '0;
  logic        m_gid = 1'b0, m_busy = 1'b0;
  state_t      m_state = ARB;
  logic        m_rdy0, m_rdy1;
  logic        o_rdy0, o_rdy1;

  task automatic model_cycle(input logic rst, input logic clr,
                             input logic v0, input logic [AW-1:0] a0, input logic [N-1:0] d0,
                             input logic v1, input logic [AW-1:0] a1, input logic [N-1:0] d1);
    int g;
    int a;
    m_rdy0 = 1'b0;
    m_rdy1 = 1'b0;
    if (!rst) begin
      clr_q.delete();
      last_g = 1;
      m_en = '0; m_data = '0; m_gid = 1'b0; m_busy = 1'b0;
    end else begin
      if (clr_q.size() == 0 && clr)
        for (int r = 1; r < REGS; r++) clr_q.push_back(r);
      if (clr_q.size() != 0) begin
        a = clr_q.pop_front();
        m_en = 32'd1 << a; m_data = '0; m_gid = 1'b0; m_busy = 1'b1;
      end else begin
        g = -1;
        if (v0 && v1)  g = 1 - last_g;
        else if (v1)   g = 1;
        else if (v0)   g = 0;
        m_busy = 1'b0;
        m_en   = '0;
        if (g >= 0) begin
          last_g = g;
          if (g == 0) m_rdy0 = 1'b1; else m_rdy1 = 1'b1;
          a = (g == 1) ? int'(a1) : int'(a0);
          m_en   = (a == 0) ? 32'd0 : (32'd1 << a);
          m_data = (g == 1) ? d1 : d0;
          m_gid  = g[0];
        end
      end
    end
    m_state = (clr_q.size() != 0) ? CLEAR : ARB;
    exp_q.push_back({m_state, m_busy, m_gid, m_data, m_en});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rst, input logic clr,
                      input logic v0, input logic [AW-1:0] a0, input logic [N-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [N-1:0] d1);
    logic [W-1:0] e;
    @(negedge clk);
    reset = rst; clr_start = clr;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    model_cycle(rst, clr, v0, a0, d0, v1, a1, d1);
    o_rdy0 = req0_ready;
    o_rdy1 = req1_ready;
    check("req0_ready", 64'(req0_ready), 64'(m_rdy0));
    check("req1_ready", 64'(req1_ready), 64'(m_rdy1));
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("wr_enable", 64'(wr_enable), 64'(e[31:0]));
    check("wr_data",   64'(wr_data),   64'(e[63:32]));
    check("grant_id",  64'(grant_id),  64'(e[64]));
    check("clr_busy",  64'(clr_busy),  64'(e[65]));
    check("fsm_state", 64'(fsm_state), 64'(e[66]));
  endtask

  task automatic idle(input logic rst);
    step(rst, 1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  logic          p0v, p1v;
  logic [AW-1:0] p0a, p1a;
  logic [N-1:0]  p0d, p1d;
  int            busy_n;

  initial begin
    // Reset for two cycles: every output zero.
    idle(1'b0);
    idle(1'b0);
    check("rst_enable", 64'(wr_enable), 64'd0);
    check("rst_busy",   64'(clr_busy),  64'd0);

    // Single write to x5.
    step(1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
    check("x5_enable", 64'(wr_enable), 64'h20);
    check("x5_data",   64'(wr_data),   64'hDEADBEEF);
    check("x5_gid",    64'(grant_id),  64'd0);

    // Ties right after reset alternate 0,1,0,1.
    idle(1'b0);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0A0A, 1'b1, 5'd7, 32'h0000_0B0B);
      check("tie_gid", 64'(grant_id), 64'(k % 2));
    end

    // Write to x0 is accepted but discarded.
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h1234);
    check("x0_ready",  64'(o_rdy1),    64'd1);
    check("x0_enable", 64'(wr_enable), 64'd0);
    idle(1'b1);

    // Clear beats a same-cycle request; req0 is accepted in the final clear cycle.
    busy_n = 0;
    step(1'b1, 1'b1, 1'b1, 5'd9, 32'hCAFE, 1'b0, '0, '0);
    check("clr_block_ready", 64'(o_rdy0), 64'd0);
    if (clr_busy) busy_n++;
    for (int k = 1; k <= 31; k++) begin
      step(1'b1, 1'b0, 1'b1, 5'd9, 32'hCAFE, 1'b0, '0, '0);
      if (clr_busy) busy_n++;
    end
    check("clr_busy_cycles", 64'(busy_n), 64'd31);
    check("clr_end_ready",   64'(o_rdy0), 64'd1);
    check("clr_end_enable",  64'(wr_enable), 64'h200);
    idle(1'b1);

    // Reset while x10 is on the port aborts the clear.
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
    for (int k = 2; k <= 10; k++) idle(1'b1);
    check("abort_at_x10", 64'(wr_enable), 64'h400);
    idle(1'b0);
    check("abort_enable", 64'(wr_enable), 64'd0);
    check("abort_busy",   64'(clr_busy),  64'd0);
    check("abort_state",  64'(fsm_state), 64'(ARB));
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      check("abort_quiet", 64'(wr_enable), 64'd0);
    end

    // Random traffic with held pending requests, occasional clears and resets.
    p0v = 1'b0; p1v = 1'b0; p0a = '0; p1a = '0; p0d = '0; p1d = '0;
    for (int k = 0; k < 500; k++) begin
      if (!p0v && $urandom_range(0, 2) != 0) begin
        p0v = 1'b1; p0a = AW'($urandom_range(0, REGS - 1)); p0d = $urandom;
      end
      if (!p1v && $urandom_range(0, 2) != 0) begin
        p1v = 1'b1; p1a = AW'($urandom_range(0, REGS - 1)); p1d = $urandom;
      end
      step($urandom_range(0, 149) != 0, $urandom_range(0, 39) == 0,
           p0v, p0a, p0d, p1v, p1a, p1d);
      if (m_rdy0) p0v = 1'b0;
      if (m_rdy1) p1v = 1'b0;
    end

    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
